// File: rtl/vg93_pkg.sv
// Shared definitions for the VG93 write-sector path: state encoding,
// fixed byte values, CRC constants and the size-code decoder.
package vg93_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_ARM, S_PRE, S_SYNC, S_MARK, S_DATA, S_CRCH, S_CRCL, S_TRAIL, S_STOP
    } state_t;

    localparam logic [7:0]  SYNC_BYTE    = 8'hA1;
    localparam logic [7:0]  MARK_NORMAL  = 8'hFB;
    localparam logic [7:0]  MARK_DELETED = 8'hF8;
    localparam logic [7:0]  GAP_BYTE     = 8'h4E;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC_POLY     = 16'h1021;

    function automatic logic [10:0] sector_len(input logic [1:0] code);
        return 11'd128 << code;
    endfunction

endpackage

// File: rtl/vg93_sector_writer_if.sv
// CPU data-register and MFM-encoder handshake bundle of the sector writer.
interface vg93_sector_writer_if;
    logic       start;
    logic       abort;
    logic [7:0] mark;
    logic [1:0] size;
    logic [7:0] data;
    logic       data_wr;
    logic       drq;
    logic       lost_data;
    logic       busy;
    logic       done;
    logic       wg;
    logic [7:0] main_2_byte;
    logic       byte_2_write;
    logic       translate;
    logic       next_byte;

    modport master (
        output start, abort, mark, size, data, data_wr, next_byte,
        input  drq, lost_data, busy, done, wg, main_2_byte, byte_2_write, translate
    );

    modport slave (
        input  start, abort, mark, size, data, data_wr, next_byte,
        output drq, lost_data, busy, done, wg, main_2_byte, byte_2_write, translate
    );
endinterface

// File: rtl/vg93_crc16.sv
// Bit-serial CRC-CCITT (poly 1021h, MSB first); one byte takes eight clocks.
module vg93_crc16
    import vg93_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  din,
    output logic [15:0] crc,
    output logic        busy
);
    logic [7:0] sh;
    logic [2:0] bitn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc  <= CRC_INIT;
            sh   <= '0;
            bitn <= '0;
            busy <= 1'b0;
        end else if (clr) begin
            crc  <= CRC_INIT;
            bitn <= '0;
            busy <= 1'b0;
        end else if (load) begin
            sh   <= din;
            bitn <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            crc  <= {crc[14:0], 1'b0} ^ ((crc[15] ^ sh[7]) ? CRC_POLY : 16'h0000);
            sh   <= {sh[6:0], 1'b0};
            bitn <= bitn + 3'd1;
            if (bitn == 3'd7) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/vg93_sector_writer.sv
// Write-sector sequencer: preamble, sync, data mark, sector data, CRC and gap
// handed to the MFM encoder one byte per NEXT_BYTE request.
module vg93_sector_writer
    import vg93_pkg::*;
#(
    parameter int         PRE_LEN    = 12,
    parameter int         SYNC_LEN   = 3,
    parameter logic [7:0] TRAIL_BYTE = GAP_BYTE
) (
    input logic                 clk,
    input logic                 rst,
    vg93_sector_writer_if.slave bus
);
    localparam logic [10:0] PRE_LAST  = 11'(PRE_LEN - 1);
    localparam logic [10:0] SYNC_LAST = 11'(SYNC_LEN - 1);

    state_t      state, state_nx;
    logic [10:0] cnt, cnt_nx;
    logic [7:0]  mark_q, mark_nx, hold, hold_nx, main, main_nx;
    logic [1:0]  size_q, size_nx;
    logic        full, full_nx, armed, armed_nx;
    logic        drq, drq_nx, lost, lost_nx, busy, busy_nx, done, done_nx;
    logic        wg, wg_nx, ack, ack_nx, trans, trans_nx;
    logic        crc_clr, crc_load, crc_busy;
    logic [15:0] crc;
    logic        abort_now, offering, svc, wr_ok, last_data;

    assign abort_now = bus.abort && (state != S_IDLE);
    // CRC bytes wait for the serial engine; in practice it is long done.
    assign offering  = (state inside {S_PRE, S_SYNC, S_MARK, S_DATA, S_CRCH, S_CRCL, S_TRAIL})
                       && !(state == S_CRCH && crc_busy);
    // armed drops on each service and re-arms once the request goes low,
    // so a request held past its ack cannot pull a second byte.
    assign svc       = offering && bus.next_byte && !ack && armed && !abort_now;
    assign wr_ok     = bus.data_wr && drq;
    assign last_data = (cnt == sector_len(size_q) - 11'd1);

    vg93_crc16 u_crc (
        .clk(clk), .rst(rst), .clr(crc_clr), .load(crc_load),
        .din(main_nx), .crc(crc), .busy(crc_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;   cnt  <= '0;   mark_q <= '0;  size_q <= '0;
            hold  <= '0;       full <= 1'b0; armed  <= 1'b1;
            drq   <= 1'b0;     lost <= 1'b0; busy   <= 1'b0; done <= 1'b0;
            wg    <= 1'b0;     main <= TRAIL_BYTE; ack  <= 1'b0; trans <= 1'b0;
        end else begin
            state <= state_nx; cnt  <= cnt_nx;  mark_q <= mark_nx; size_q <= size_nx;
            hold  <= hold_nx;  full <= full_nx; armed  <= armed_nx;
            drq   <= drq_nx;   lost <= lost_nx; busy   <= busy_nx; done <= done_nx;
            wg    <= wg_nx;    main <= main_nx; ack    <= ack_nx;  trans <= trans_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (abort_now) state_nx = S_IDLE;
        else begin
            case (state)
                S_IDLE:  if (bus.start) state_nx = S_ARM;
                S_ARM:   state_nx = S_PRE;
                S_PRE:   if (svc && cnt == PRE_LAST)  state_nx = S_SYNC;
                S_SYNC:  if (svc && cnt == SYNC_LAST) state_nx = S_MARK;
                S_MARK:  if (svc) state_nx = S_DATA;
                S_DATA:  if (svc && last_data) state_nx = S_CRCH;
                S_CRCH:  if (svc) state_nx = S_CRCL;
                S_CRCL:  if (svc) state_nx = S_TRAIL;
                S_TRAIL: if (svc && cnt != 11'd0) state_nx = S_STOP;
                S_STOP:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_nx   = cnt;   mark_nx = mark_q; size_nx = size_q; hold_nx = hold;
        full_nx  = full;  drq_nx  = drq;    lost_nx = lost;   busy_nx = busy;
        done_nx  = 1'b0;  wg_nx   = wg;     main_nx = main;   ack_nx  = 1'b0;
        trans_nx = trans; armed_nx = armed | ~bus.next_byte;
        crc_clr  = 1'b0;  crc_load = 1'b0;
        if (wr_ok) begin
            hold_nx = bus.data;
            full_nx = 1'b1;
            drq_nx  = 1'b0;
        end
        if (svc) begin
            ack_nx   = 1'b1;
            armed_nx = 1'b0;
            cnt_nx   = cnt + 11'd1;
        end
        if (abort_now) begin
            wg_nx = 1'b0; drq_nx = 1'b0; trans_nx = 1'b0; busy_nx = 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    mark_nx = bus.mark; size_nx = bus.size;
                    busy_nx = 1'b1;     crc_clr = 1'b1;  lost_nx = 1'b0;
                    drq_nx  = 1'b1;     full_nx = 1'b0;  main_nx = 8'h00; cnt_nx = '0;
                end
                S_ARM: begin
                    wg_nx  = 1'b1;
                    cnt_nx = 11'd1;
                end
                S_PRE: if (svc) begin
                    main_nx = 8'h00;
                    if (cnt == PRE_LAST) cnt_nx = '0;
                end
                S_SYNC: if (svc) begin
                    main_nx  = SYNC_BYTE; crc_load = 1'b1; trans_nx = 1'b1;
                    if (cnt == SYNC_LAST) cnt_nx = '0;
                end
                S_MARK: if (svc) begin
                    main_nx = mark_q; crc_load = 1'b1; cnt_nx = '0;
                end
                // A write landing on the handoff edge loads after the old byte is taken.
                S_DATA: if (svc) begin
                    main_nx  = full ? hold : 8'h00;
                    lost_nx  = lost | ~full;
                    crc_load = 1'b1;
                    trans_nx = 1'b0;
                    full_nx  = wr_ok;
                    drq_nx   = wr_ok ? 1'b0 : ~last_data;
                    if (last_data) cnt_nx = '0;
                end
                S_CRCH:  if (svc) main_nx = crc[15:8];
                S_CRCL:  if (svc) begin main_nx = crc[7:0]; cnt_nx = '0; end
                S_TRAIL: if (svc) main_nx = TRAIL_BYTE;
                S_STOP: begin
                    wg_nx = 1'b0; done_nx = 1'b1; busy_nx = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.drq          = drq;
    assign bus.lost_data    = lost;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.wg           = wg;
    assign bus.main_2_byte  = main;
    assign bus.byte_2_write = ack;
    assign bus.translate    = trans;
endmodule

// File: tb/tb_vg93_sector_writer.sv
// Sector-writer bench: randomized sector payloads, an encoder that requests a
// byte at a fixed interval, a CPU that answers DRQ, and a byte-stream model.
module tb_vg93_sector_writer;
    import vg93_pkg::*;

    localparam int PERIOD = 24;
    localparam int HDR    = 15;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vg93_sector_writer_if bus();
    vg93_sector_writer dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0, failures = 0;
    logic [7:0] payload [1024];
    logic [7:0] ack_q [$];
    logic       tr_q [$];
    int done_cnt, req_cnt, enc_hold, skip_idx, cpu_k;
    bit enc_en, cpu_en, mon_en;

    initial forever begin
        @(negedge clk);
        if (mon_en && bus.byte_2_write) begin
            ack_q.push_back(bus.main_2_byte);
            tr_q.push_back(bus.translate);
        end
        if (mon_en && bus.done) done_cnt++;
    end

    initial begin
        int tmr, hc;
        bit acked;
        bus.next_byte = 1'b0; tmr = 0; hc = 0; acked = 0;
        forever begin
            @(negedge clk);
            if (!enc_en) begin
                bus.next_byte = 1'b0; tmr = 0; acked = 0;
            end else if (bus.next_byte) begin
                if (bus.byte_2_write) begin acked = 1; hc = enc_hold; end
                if (acked) begin
                    if (hc == 0) begin bus.next_byte = 1'b0; tmr = 0; acked = 0; end
                    else hc--;
                end
            end else begin
                tmr++;
                if (tmr >= PERIOD) begin bus.next_byte = 1'b1; req_cnt++; end
            end
        end
    end

    initial begin
        bus.data = 8'h00; bus.data_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (cpu_en && bus.drq) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
                if (cpu_k == skip_idx) begin
                    while (cpu_en && ack_q.size() <= HDR + skip_idx) @(negedge clk);
                end else if (cpu_en) begin
                    bus.data = payload[cpu_k]; bus.data_wr = 1'b1;
                    @(negedge clk);
                    bus.data_wr = 1'b0;
                end
                cpu_k++;
            end
        end
    end

    function automatic logic [15:0] crc_model(input bq_t b);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[i])
            for (int k = 7; k >= 0; k--)
                c = (c[15] ^ b[i][k]) ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    function automatic bq_t build_exp(input int n, input logic [7:0] mk, input int skip);
        bq_t q, c;
        logic [15:0] r;
        logic [7:0] d;
        for (int i = 0; i < 11; i++) q.push_back(8'h00);
        for (int i = 0; i < 3; i++) begin q.push_back(8'hA1); c.push_back(8'hA1); end
        q.push_back(mk); c.push_back(mk);
        for (int i = 0; i < n; i++) begin
            d = (i == skip) ? 8'h00 : payload[i];
            q.push_back(d); c.push_back(d);
        end
        r = crc_model(c);
        q.push_back(r[15:8]); q.push_back(r[7:0]);
        q.push_back(8'h4E);   q.push_back(8'h4E);
        return q;
    endfunction

    task automatic start_write(input logic [1:0] sz, input logic [7:0] mk, input int skip, input int hold);
        for (int i = 0; i < 1024; i++) payload[i] = 8'($urandom);
        ack_q.delete(); tr_q.delete();
        done_cnt = 0; req_cnt = 0; cpu_k = 0; skip_idx = skip; enc_hold = hold; mon_en = 1;
        @(negedge clk);
        bus.size = sz; bus.mark = mk; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; enc_en = 1; cpu_en = 1;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int t;
        t = 0;
        while (bus.busy && t < limit) begin @(negedge clk); t++; end
        ok = !bus.busy;
        repeat (3) @(negedge clk);
        enc_en = 0; cpu_en = 0;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.mark = 8'h00; bus.size = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.drq !== 1'b0)          begin failures++; $display("FAIL rst_drq got=%b exp=0", bus.drq); end
        checks++; if (bus.lost_data !== 1'b0)    begin failures++; $display("FAIL rst_lost got=%b exp=0", bus.lost_data); end
        checks++; if (bus.busy !== 1'b0)         begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0)         begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        checks++; if (bus.wg !== 1'b0)           begin failures++; $display("FAIL rst_wg got=%b exp=0", bus.wg); end
        checks++; if (bus.main_2_byte !== 8'h4E) begin failures++; $display("FAIL rst_main got=%02h exp=4e", bus.main_2_byte); end
        checks++; if (bus.byte_2_write !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", bus.byte_2_write); end
        checks++; if (bus.translate !== 1'b0)    begin failures++; $display("FAIL rst_translate got=%b exp=0", bus.translate); end
        checks++; if (dut.crc !== 16'hFFFF)      begin failures++; $display("FAIL rst_crc got=%04h exp=ffff", dut.crc); end
    endtask

    task automatic test_normal;
        bq_t exp;
        bit ok;
        int t, bad;
        start_write(2'd0, 8'hFB, -1, 0);
        checks++; if (bus.busy !== 1'b1 || bus.drq !== 1'b1) begin failures++; $display("FAIL start_flags got busy=%b drq=%b exp 1 1", bus.busy, bus.drq); end
        checks++; if (bus.wg !== 1'b0 || bus.main_2_byte !== 8'h00) begin failures++; $display("FAIL arm_preload got wg=%b byte=%02h exp 0 00", bus.wg, bus.main_2_byte); end
        payload[7] = 8'hA1;
        t = 0;
        while (ack_q.size() < 14 && t < 40 * PERIOD) begin @(negedge clk); t++; end
        repeat (10) @(negedge clk);
        checks++; if (dut.crc !== 16'hCDB4) begin failures++; $display("FAIL sync_crc got=%04h exp=cdb4", dut.crc); end
        wait_idle(400 * PERIOD, ok);
        checks++; if (!ok) begin failures++; $display("FAIL normal_timeout got busy exp idle"); end
        exp = build_exp(128, 8'hFB, -1);
        checks++; if (ack_q.size() !== exp.size()) begin failures++; $display("FAIL normal_count got=%0d exp=%0d", ack_q.size(), exp.size()); end
        bad = -1;
        for (int i = 0; i < exp.size() && i < ack_q.size(); i++) if (bad < 0 && ack_q[i] !== exp[i]) bad = i;
        checks++; if (bad >= 0) begin failures++; $display("FAIL normal_seq idx=%0d got=%02h exp=%02h", bad, ack_q[bad], exp[bad]); end
        bad = -1;
        for (int i = 0; i < tr_q.size(); i++) if (bad < 0 && tr_q[i] !== (i >= 11 && i < HDR)) bad = i;
        checks++; if (bad >= 0) begin failures++; $display("FAIL translate_window idx=%0d got=%b", bad, tr_q[bad]); end
        checks++; if (ack_q.size() > HDR + 7 && (ack_q[HDR + 7] !== 8'hA1 || tr_q[HDR + 7] !== 1'b0))
            begin failures++; $display("FAIL payload_a1 got byte=%02h tr=%b exp a1 0", ack_q[HDR + 7], tr_q[HDR + 7]); end
        checks++; if (done_cnt !== 1)          begin failures++; $display("FAIL normal_done got=%0d exp=1", done_cnt); end
        checks++; if (bus.wg !== 1'b0 || bus.lost_data !== 1'b0 || bus.drq !== 1'b0)
            begin failures++; $display("FAIL normal_end got wg=%b lost=%b drq=%b exp 0 0 0", bus.wg, bus.lost_data, bus.drq); end
    endtask

    task automatic test_lost_data;
        bq_t exp;
        bit ok;
        int bad;
        start_write(2'd0, 8'hF8, 5, 0);
        wait_idle(400 * PERIOD, ok);
        checks++; if (!ok) begin failures++; $display("FAIL lost_timeout got busy exp idle"); end
        exp = build_exp(128, 8'hF8, 5);
        checks++; if (ack_q.size() !== exp.size()) begin failures++; $display("FAIL lost_count got=%0d exp=%0d", ack_q.size(), exp.size()); end
        bad = -1;
        for (int i = 0; i < exp.size() && i < ack_q.size(); i++) if (bad < 0 && ack_q[i] !== exp[i]) bad = i;
        checks++; if (bad >= 0) begin failures++; $display("FAIL lost_seq idx=%0d got=%02h exp=%02h", bad, ack_q[bad], exp[bad]); end
        checks++; if (bus.lost_data !== 1'b1) begin failures++; $display("FAIL lost_flag got=%b exp=1", bus.lost_data); end
        checks++; if (done_cnt !== 1)         begin failures++; $display("FAIL lost_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_abort;
        int t;
        start_write(2'd1, 8'hFB, 10, 0);
        t = 0;
        while (ack_q.size() < HDR + 41 && t < 200 * PERIOD) begin @(negedge clk); t++; end
        checks++; if (ack_q.size() !== HDR + 41) begin failures++; $display("FAIL abort_reach got=%0d exp=%0d", ack_q.size(), HDR + 41); end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++; if (bus.wg !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL abort_stop got wg=%b busy=%b exp 0 0", bus.wg, bus.busy); end
        checks++; if (bus.drq !== 1'b0 || bus.translate !== 1'b0 || bus.byte_2_write !== 1'b0)
            begin failures++; $display("FAIL abort_flags got drq=%b tr=%b ack=%b exp 0 0 0", bus.drq, bus.translate, bus.byte_2_write); end
        checks++; if (bus.lost_data !== 1'b1) begin failures++; $display("FAIL abort_lost_kept got=%b exp=1", bus.lost_data); end
        repeat (4 * PERIOD) @(negedge clk);
        checks++; if (ack_q.size() !== HDR + 41) begin failures++; $display("FAIL abort_no_acks got=%0d exp=%0d", ack_q.size(), HDR + 41); end
        checks++; if (done_cnt !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
        enc_en = 0; cpu_en = 0;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bq_t exp;
        bit ok;
        int t, bad;
        start_write(2'd3, 8'hFB, -1, 3);
        t = 0;
        while (ack_q.size() < 100 && t < 200 * PERIOD) begin @(negedge clk); t++; end
        bus.mark = 8'hF8; bus.size = 2'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(1200 * (PERIOD + 8), ok);
        checks++; if (!ok) begin failures++; $display("FAIL size3_timeout got busy exp idle"); end
        exp = build_exp(1024, 8'hFB, -1);
        checks++; if (ack_q.size() !== exp.size()) begin failures++; $display("FAIL size3_count got=%0d exp=%0d", ack_q.size(), exp.size()); end
        bad = -1;
        for (int i = 0; i < exp.size() && i < ack_q.size(); i++) if (bad < 0 && ack_q[i] !== exp[i]) bad = i;
        checks++; if (bad >= 0) begin failures++; $display("FAIL size3_seq idx=%0d got=%02h exp=%02h", bad, ack_q[bad], exp[bad]); end
        checks++; if (req_cnt !== ack_q.size()) begin failures++; $display("FAIL hold_one_per_req got acks=%0d exp=%0d", ack_q.size(), req_cnt); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL size3_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid_sync;
        bq_t exp;
        bit ok;
        int t, bad;
        start_write(2'd0, 8'hFB, -1, 0);
        t = 0;
        while (ack_q.size() < 12 && t < 40 * PERIOD) begin @(negedge clk); t++; end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.wg !== 1'b0) begin failures++; $display("FAIL rst_async_wg got=%b exp=0", bus.wg); end
        checks++; if (bus.busy !== 1'b0 || bus.drq !== 1'b0 || bus.translate !== 1'b0 || bus.byte_2_write !== 1'b0 || bus.done !== 1'b0)
            begin failures++; $display("FAIL rst_mid_flags got busy=%b drq=%b tr=%b ack=%b done=%b exp 0", bus.busy, bus.drq, bus.translate, bus.byte_2_write, bus.done); end
        checks++; if (bus.main_2_byte !== 8'h4E || dut.crc !== 16'hFFFF)
            begin failures++; $display("FAIL rst_mid_regs got byte=%02h crc=%04h exp 4e ffff", bus.main_2_byte, dut.crc); end
        enc_en = 0; cpu_en = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        start_write(2'd0, 8'hFB, -1, 0);
        wait_idle(400 * PERIOD, ok);
        checks++; if (!ok) begin failures++; $display("FAIL restart_timeout got busy exp idle"); end
        exp = build_exp(128, 8'hFB, -1);
        checks++; if (ack_q.size() !== exp.size()) begin failures++; $display("FAIL restart_count got=%0d exp=%0d", ack_q.size(), exp.size()); end
        bad = -1;
        for (int i = 0; i < exp.size() && i < ack_q.size(); i++) if (bad < 0 && ack_q[i] !== exp[i]) bad = i;
        checks++; if (bad >= 0) begin failures++; $display("FAIL restart_seq idx=%0d got=%02h exp=%02h", bad, ack_q[bad], exp[bad]); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL restart_done got=%0d exp=1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_lost_data();
        test_abort();
        test_back_to_back();
        test_reset_mid_sync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
